fir_mac_engine: RTL and testbench

- Parametrised, time-multiplexed, multichannel FIR multiply-accumulate engine. It replaces the single fixed-width tap.
- On one start pulse it sequences NUM_TAPS reads of coefficients and delay-line samples from external memories.
- It runs a pipelined signed MAC, then rounds, scales and range-limits the sum. The result is presented with a one-cycle valid strobe and its channel tag.
- It sits between the sample delay-line RAM and coefficient RAM on one side and the audio output path on the other.

---
 rtl/fir_mac_engine.sv | 163 ++++++++++++++++
 tb/tb_fir_mac_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - time-multiplexed multichannel FIR multiply-accumulate engine
// Define FIR_MAC_SATURATE_EN to clamp the rounded result to OUT_W and flag clip; otherwise it wraps.
module fir_mac_engine #(
  parameter int DATA_W    = 24,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 15,
  parameter int ACC_W     = 48,
  parameter int OUT_W     = 24,
  parameter int NUM_TAPS  = 64,
  parameter int NUM_CH    = 2,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W    = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [CH_W-1:0]        start_ch,
  output logic                   busy,
  output logic                   tap_rd,
  output logic [CH_W+TAP_W-1:0]  tap_addr,
  input  logic [COEF_W-1:0]      coef_in,
  input  logic [DATA_W-1:0]      data_in,
  output logic [OUT_W-1:0]       data_out,
  output logic [CH_W-1:0]        out_ch,
  output logic                   out_valid,
  output logic                   clip
);
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t            state_q;
  logic              busy_q, tap_rd_q, out_valid_q, clip_q;
  logic [CH_W-1:0]   ch_q, out_ch_q;
  logic [TAP_W-1:0]  tap_q;
  logic [1:0]        drain_q;
  logic [OUT_W-1:0]  data_out_q;

  logic              start_ok;
  logic [OUT_W-1:0]  data_d;
  logic              clip_d;

  assign start_ok = (state_q == IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      tap_rd_q    <= 1'b0;
      tap_q       <= '0;
      ch_q        <= '0;
      drain_q     <= '0;
      out_valid_q <= 1'b0;
      clip_q      <= 1'b0;
      data_out_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= ISSUE;
            busy_q   <= 1'b1;
            tap_rd_q <= 1'b1;
            tap_q    <= '0;
            ch_q     <= (NUM_CH == 1) ? '0 : start_ch;
          end
        end
        ISSUE: begin
          if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
            state_q  <= DRAIN;
            tap_rd_q <= 1'b0;
            tap_q    <= '0;
            drain_q  <= '0;
          end else begin
            tap_q <= tap_q + TAP_W'(1);
          end
        end
        DRAIN: begin
          // three cycles covers operand, product and accumulate stages of the last tap
          if (drain_q == 2'd2) state_q <= OUTPUT;
          else                 drain_q <= drain_q + 2'd1;
        end
        OUTPUT: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b1;
          data_out_q  <= data_d;
          clip_q      <= clip_d;
          out_ch_q    <= ch_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  logic                     rd_d1_q, op_vld_q, prod_vld_q;
  logic signed [DATA_W-1:0] data_op_q;
  logic signed [COEF_W-1:0] coef_op_q;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_d1_q    <= 1'b0;
      op_vld_q   <= 1'b0;
      prod_vld_q <= 1'b0;
      data_op_q  <= '0;
      coef_op_q  <= '0;
      prod_q     <= '0;
      acc_q      <= '0;
    end else begin
      rd_d1_q    <= tap_rd_q;
      op_vld_q   <= rd_d1_q;
      prod_vld_q <= op_vld_q;
      if (rd_d1_q) begin
        data_op_q <= data_in;
        coef_op_q <= coef_in;
      end
      if (op_vld_q) prod_q <= PROD_W'(data_op_q) * PROD_W'(coef_op_q);
      if (start_ok)        acc_q <= '0;
      else if (prod_vld_q) acc_q <= acc_q + {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    end
  end

  // one guard bit above ACC_W so the rounding add cannot overflow
  localparam logic signed [ACC_W:0] RND_HALF = (ACC_W+1)'(1) <<< (COEF_FRAC - 1);
  logic signed [ACC_W:0] rnd, r_full;

`ifdef FIR_MAC_SATURATE_EN
  localparam logic signed [ACC_W:0] SAT_MAX = ((ACC_W+1)'(1) <<< (OUT_W - 1)) - (ACC_W+1)'(1);
  localparam logic signed [ACC_W:0] SAT_MIN = -((ACC_W+1)'(1) <<< (OUT_W - 1));
`endif

  always_comb begin
    rnd    = $signed({acc_q[ACC_W-1], acc_q}) + RND_HALF;
    r_full = rnd >>> COEF_FRAC;
`ifdef FIR_MAC_SATURATE_EN
    if (r_full > SAT_MAX) begin
      data_d = OUT_W'(SAT_MAX);
      clip_d = 1'b1;
    end else if (r_full < SAT_MIN) begin
      data_d = OUT_W'(SAT_MIN);
      clip_d = 1'b1;
    end else begin
      data_d = OUT_W'(r_full);
      clip_d = 1'b0;
    end
`else
    data_d = OUT_W'(r_full);
    clip_d = 1'b0;
`endif
  end

  assign busy      = busy_q;
  assign tap_rd    = tap_rd_q;
  assign tap_addr  = tap_rd_q ? {ch_q, tap_q} : '0;
  assign data_out  = data_out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign clip      = clip_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb/tb_fir_mac_engine.sv - self-checking bench for fir_mac_engine (NUM_TAPS=4, NUM_CH=2)
module tb_fir_mac_engine;
  localparam int N    = 4;
  localparam int CH_W = 1;
  localparam int AW   = 3;

  logic             clk = 1'b0;
  logic             reset, start;
  logic [CH_W-1:0]  start_ch;
  logic             busy, tap_rd;
  logic [AW-1:0]    tap_addr;
  logic [15:0]      coef_in;
  logic [23:0]      data_in;
  logic [23:0]      data_out;
  logic [CH_W-1:0]  out_ch;
  logic             out_valid, clip;

  fir_mac_engine #(.NUM_TAPS(N), .NUM_CH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .start_ch(start_ch),
    .busy(busy), .tap_rd(tap_rd), .tap_addr(tap_addr),
    .coef_in(coef_in), .data_in(data_in),
    .data_out(data_out), .out_ch(out_ch), .out_valid(out_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  logic signed [23:0] dmem [8];
  logic signed [15:0] cmem [8];

  // memories answer one cycle after the read strobe; junk is driven otherwise
  logic rd_prev = 1'b0;
  int   addr_prev = 0;
  always @(negedge clk) begin
    if (rd_prev === 1'b1) begin
      data_in = dmem[addr_prev];
      coef_in = cmem[addr_prev];
    end else begin
      data_in = 24'($urandom);
      coef_in = 16'($urandom);
    end
    rd_prev   = tap_rd;
    addr_prev = int'(tap_addr);
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic void model(input int ch, output logic [23:0] ed, output logic ec);
    longint acc, r;
    acc = 0;
    for (int k = 0; k < N; k++)
      acc += longint'(dmem[ch*N+k]) * longint'(cmem[ch*N+k]);
    r = (acc + 64'sd16384) >>> 15;
`ifdef FIR_MAC_SATURATE_EN
    if (r > 64'sd8388607)       begin ed = 24'h7FFFFF; ec = 1'b1; end
    else if (r < -64'sd8388608) begin ed = 24'h800000; ec = 1'b1; end
    else                        begin ed = r[23:0];    ec = 1'b0; end
`else
    ed = r[23:0];
    ec = 1'b0;
`endif
  endfunction

  task automatic run_pass(input string tag, input logic [CH_W-1:0] ch,
                          input logic [23:0] ed, input logic ec,
                          input bit skip_start, input bit glitch3,
                          input bit chain, input logic [CH_W-1:0] nch);
    logic [15:0] busy_v, rd_v, busy_e, rd_e;
    logic [15:0] addr_v, addr_e;
    logic [23:0] dout;
    logic [CH_W-1:0] och;
    logic cl;
    int vcnt, vcyc, last;
    if (!skip_start) begin
      start = 1'b1;
      start_ch = ch;
    end
    @(posedge clk); #1;
    start = 1'b0;
    busy_v = '0; rd_v = '0; addr_v = '0; busy_e = '0; rd_e = '0; addr_e = '0;
    vcnt = 0; vcyc = 0; dout = 'x; och = 'x; cl = 1'bx;
    last = chain ? N + 5 : N + 8;
    for (int c = 1; c <= last; c++) begin
      busy_v[c] = busy;
      rd_v[c]   = tap_rd;
      busy_e[c] = (c <= N + 4);
      rd_e[c]   = (c <= N);
      if (c <= N) begin
        addr_v[(c-1)*AW +: AW] = tap_addr;
        addr_e[(c-1)*AW +: AW] = {ch, 2'(c - 1)};
      end
      if (out_valid === 1'b1) begin
        vcnt++;
        if (vcyc == 0) begin
          vcyc = c; dout = data_out; och = out_ch; cl = clip;
        end
      end
      if (glitch3 && c == 3) begin start = 1'b1; start_ch = ~ch; end
      if (glitch3 && c == 4) start = 1'b0;
      if (chain && c == N + 5) begin
        start = 1'b1;
        start_ch = nch;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, ".busy"},    64'(busy_v), 64'(busy_e));
    check({tag, ".tap_rd"},  64'(rd_v),   64'(rd_e));
    check({tag, ".addr"},    64'(addr_v), 64'(addr_e));
    check({tag, ".vcycle"},  64'(vcyc),   64'(N + 5));
    check({tag, ".vcount"},  64'(vcnt),   64'd1);
    check({tag, ".data"},    64'(dout),   64'(ed));
    check({tag, ".out_ch"},  64'(och),    64'(ch));
    check({tag, ".clip"},    64'(cl),     64'(ec));
  endtask

  typedef struct {
    string            name;
    logic [CH_W-1:0]  ch;
    logic [3:0][23:0] d;
    logic [3:0][15:0] k;
    logic [23:0]      o_wrap;
    logic [23:0]      o_sat;
    logic             c_sat;
  } vec_t;

  vec_t vecs [7];

  task automatic load_mem(input logic [CH_W-1:0] ch, input logic [3:0][23:0] d, input logic [3:0][15:0] k);
    for (int i = 0; i < N; i++) begin
      dmem[int'(ch)*N+i] = d[i];
      cmem[int'(ch)*N+i] = k[i];
    end
  endtask

  initial begin
    logic [23:0] ed;
    logic ec, cv;
    logic [CH_W-1:0] rch;
    logic [3:0][23:0] rd;
    logic [3:0][15:0] rk;
    int vc;

    vecs[0] = '{"gain",   1'b0, {4{24'h100000}}, {4{16'h4000}}, 24'h200000, 24'h200000, 1'b0};
    vecs[1] = '{"rnd_up", 1'b0, {24'h123456, 24'h123456, 24'h123456, 24'h000001},
                {16'h0, 16'h0, 16'h0, 16'h4000}, 24'h000001, 24'h000001, 1'b0};
    vecs[2] = '{"rnd_dn", 1'b0, {24'h123456, 24'h123456, 24'h123456, 24'h000001},
                {16'h0, 16'h0, 16'h0, 16'h3FFF}, 24'h000000, 24'h000000, 1'b0};
    vecs[3] = '{"rnd_neg", 1'b0, {24'h123456, 24'h123456, 24'h123456, 24'hFFFFFF},
                {16'h0, 16'h0, 16'h0, 16'h4000}, 24'h000000, 24'h000000, 1'b0};
    vecs[4] = '{"sat_pos", 1'b0, {4{24'h7FFFFF}}, {4{16'h7FFF}}, 24'hFFFBFC, 24'h7FFFFF, 1'b1};
    vecs[5] = '{"sat_neg", 1'b0, {4{24'h800000}}, {4{16'h7FFF}}, 24'h000400, 24'h800000, 1'b1};
    vecs[6] = '{"chan1",  1'b1, {4{24'h000100}}, {4{16'h7FFF}}, 24'h000400, 24'h000400, 1'b0};

    for (int i = 0; i < 8; i++) begin dmem[i] = '0; cmem[i] = '0; end
    reset = 1'b1; start = 1'b1; start_ch = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",      64'(busy),      64'd0);
    check("rst.tap_rd",    64'(tap_rd),    64'd0);
    check("rst.tap_addr",  64'(tap_addr),  64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.clip",      64'(clip),      64'd0);
    check("rst.data_out",  64'(data_out),  64'd0);
    check("rst.out_ch",    64'(out_ch),    64'd0);
    reset = 1'b0; start = 1'b0; start_ch = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      load_mem(vecs[i].ch, vecs[i].d, vecs[i].k);
`ifdef FIR_MAC_SATURATE_EN
      run_pass(vecs[i].name, vecs[i].ch, vecs[i].o_sat, vecs[i].c_sat, 1'b0, 1'b0, 1'b0, 1'b0);
`else
      run_pass(vecs[i].name, vecs[i].ch, vecs[i].o_wrap, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    end

    // start during a pass is dropped; start coincident with out_valid chains
    load_mem(1'b0, {4{24'h100000}}, {4{16'h4000}});
    run_pass("ignore", 1'b0, 24'h200000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_pass("b2b_a",  1'b0, 24'h200000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    run_pass("b2b_b",  1'b1, 24'h000400, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset at cycle 2 of ISSUE
    start = 1'b1; start_ch = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst.busy",     64'(busy),     64'd0);
    check("midrst.tap_rd",   64'(tap_rd),   64'd0);
    check("midrst.data_out", 64'(data_out), 64'd0);
    reset = 1'b0;
    vc = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vc++;
    end
    check("midrst.no_valid", 64'(vc), 64'd0);
    run_pass("post_rst", 1'b0, 24'h200000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rch = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++) begin
        rd[i] = 24'($urandom);
        rk[i] = 16'($urandom);
        if (t[0]) rd[i] = 24'($signed(rd[i]) >>> 6);
      end
      load_mem(rch, rd, rk);
      model(int'(rch), ed, ec);
      run_pass($sformatf("rand%0d", t), rch, ed, ec, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    cv = clip;
    check("idle.clip_held", 64'(clip), 64'(cv));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
